// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: in-order instruction/PC queue between fetch and decode.
// A circular buffer with wrap-bit pointers. Handshakes are valid/ready on both sides.
// A redirect flush empties the queue in one cycle.
// All outputs come from registered state only, so there is no input-to-output
// combinational path.

module riscv_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,

    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [31:0]   in_instr_i,
    input  logic [29:0]   in_pc_i,

    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [31:0]   out_instr_o,
    output logic [29:0]   out_pc_o,

    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Storage is intentionally left unreset; validity is tracked by the pointers.
    logic [31:0]   instr_mem [DEPTH];
    logic [29:0]   pc_mem    [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          push;
    logic          pop;

    // Status flags from the pointers: equal means empty, and differing only in the wrap bit means full.
    always_comb begin
        empty_o     = (wr_ptr_q == rd_ptr_q);
        full_o      = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
        in_ready_o  = !full_o;
        out_valid_o = !empty_o;
        count_o     = count_q;
    end

    // Head entry is shown combinationally from storage (first-word fall-through).
    always_comb begin
        out_instr_o = instr_mem[rd_ptr_q[AW-1:0]];
        out_pc_o    = pc_mem[rd_ptr_q[AW-1:0]];
    end

    // Handshake qualification; a flush cancels both sides for this cycle.
    always_comb begin
        push = in_valid_i && in_ready_o && !flush_i;
        pop  = out_valid_o && out_ready_i && !flush_i;
    end

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset outranks flush and any handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write at the write pointer.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            instr_mem[wr_ptr_q[AW-1:0]] <= in_instr_i;
            pc_mem[wr_ptr_q[AW-1:0]]    <= in_pc_i;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Self-checking bench for riscv_fetch_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.

module tb_riscv_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_i, flush_i, in_valid_i, out_ready_i;
    logic [31:0]   in_instr_i;
    logic [29:0]   in_pc_i;
    logic          in_ready_o, out_valid_o, empty_o, full_o;
    logic [31:0]   out_instr_o;
    logic [29:0]   out_pc_o;
    logic [CW-1:0] count_o;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [29:0] pc;
    } ent_t;

    ent_t mq[$];
    bit   model_ok = 1'b0;

    typedef struct {
        bit          rst;
        bit          fl;
        bit          iv;
        logic [29:0] pc;
        bit          ordy;
        bit          chk;
        int          cnt;
        logic [29:0] hpc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    riscv_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_instr_i  (in_instr_i),
        .in_pc_i     (in_pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_instr_o (out_instr_o),
        .out_pc_o    (out_pc_o),
        .count_o     (count_o),
        .empty_o     (empty_o),
        .full_o      (full_o)
    );

    // addi x(pc), x0, pc -- gives the directed entries recognisable encodings
    function automatic logic [31:0] ins(logic [29:0] pc);
        logic [31:0] p;
        p = {2'b00, pc};
        return 32'h0000_0013 | (p << 20) | (p << 7);
    endfunction

    function automatic vec_t mk(bit rst, bit fl, bit iv, logic [29:0] pc, bit ordy,
                                bit chk, int cnt, logic [29:0] hpc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.chk = chk; v.cnt = cnt; v.hpc = hpc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Check all status outputs against an expected occupancy.
    task automatic chk_cnt(string name, int cnt);
        chk({name, ".count"}, 32'(count_o), 32'(cnt));
        chk({name, ".empty"}, 32'(empty_o), 32'(cnt == 0));
        chk({name, ".full"}, 32'(full_o), 32'(cnt == DEPTH));
        chk({name, ".in_ready"}, 32'(in_ready_o), 32'(cnt != DEPTH));
        chk({name, ".out_valid"}, 32'(out_valid_o), 32'(cnt != 0));
    endtask

    // Drive one cycle's inputs at the falling edge and compare against the model.
    task automatic step(bit rst, bit fl, bit iv, logic [31:0] instr, logic [29:0] pc,
                        bit ordy);
        @(negedge clk);
        reset_i     = rst;
        flush_i     = fl;
        in_valid_i  = iv;
        in_instr_i  = instr;
        in_pc_i     = pc;
        out_ready_i = ordy;
        if (model_ok) begin
            chk_cnt("model", mq.size());
            if (mq.size() > 0) begin
                chk("model.head_pc", 32'(out_pc_o), 32'(mq[0].pc));
                chk("model.head_instr", out_instr_o, mq[0].instr);
            end
        end
    endtask

    // Advance through the rising edge and update the model from the applied inputs.
    task automatic tick();
        int  sz;
        bit  do_push, do_pop;
        ent_t e;
        @(posedge clk);
        sz = mq.size();
        if (reset_i || flush_i) begin
            mq.delete();
        end else begin
            do_pop  = (sz > 0) && out_ready_i;
            do_push = in_valid_i && (sz < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.instr = in_instr_i;
                e.pc    = in_pc_i;
                mq.push_back(e);
            end
        end
        if (reset_i) model_ok = 1'b1;
    endtask

    initial begin
        reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_instr_i = '0; in_pc_i = '0;

        // rst fl iv pc ordy | chk cnt head_pc
        vecs.push_back(mk(1, 0, 0, 30'h0,   0, 0, 0, 30'h0));
        vecs.push_back(mk(0, 0, 0, 30'h0,   0, 1, 0, 30'h0));
        vecs.push_back(mk(0, 0, 1, 30'h0,   0, 1, 0, 30'h0));
        vecs.push_back(mk(0, 0, 1, 30'h1,   0, 1, 1, 30'h0));
        vecs.push_back(mk(0, 0, 1, 30'h2,   0, 1, 2, 30'h0));
        vecs.push_back(mk(0, 0, 0, 30'h0,   0, 1, 3, 30'h0));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 3, 30'h0));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 2, 30'h1));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 1, 30'h2));
        vecs.push_back(mk(0, 0, 0, 30'h0,   0, 1, 0, 30'h0));
        // fill to full, 5th offer held until a slot opens
        vecs.push_back(mk(0, 0, 1, 30'd10,  0, 1, 0, 30'h0));
        vecs.push_back(mk(0, 0, 1, 30'd11,  0, 1, 1, 30'd10));
        vecs.push_back(mk(0, 0, 1, 30'd12,  0, 1, 2, 30'd10));
        vecs.push_back(mk(0, 0, 1, 30'd13,  0, 1, 3, 30'd10));
        vecs.push_back(mk(0, 0, 1, 30'd14,  0, 1, 4, 30'd10));
        vecs.push_back(mk(0, 0, 1, 30'd14,  1, 1, 4, 30'd10));
        vecs.push_back(mk(0, 0, 1, 30'd14,  0, 1, 3, 30'd11));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 4, 30'd11));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 3, 30'd12));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 2, 30'd13));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 1, 30'd14));
        vecs.push_back(mk(0, 0, 0, 30'h0,   0, 1, 0, 30'h0));
        // flush with a same-cycle push and pop
        vecs.push_back(mk(0, 0, 1, 30'h20,  0, 1, 0, 30'h0));
        vecs.push_back(mk(0, 0, 1, 30'h21,  0, 1, 1, 30'h20));
        vecs.push_back(mk(0, 0, 1, 30'h22,  0, 1, 2, 30'h20));
        vecs.push_back(mk(0, 1, 1, 30'h100, 1, 1, 3, 30'h20));
        vecs.push_back(mk(0, 0, 1, 30'h200, 1, 1, 0, 30'h0));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 1, 30'h200));
        vecs.push_back(mk(0, 0, 0, 30'h0,   0, 1, 0, 30'h0));
        // reset beats a simultaneous flush and handshakes
        vecs.push_back(mk(0, 0, 1, 30'h30,  0, 1, 0, 30'h0));
        vecs.push_back(mk(0, 0, 1, 30'h31,  0, 1, 1, 30'h30));
        vecs.push_back(mk(1, 1, 1, 30'h32,  1, 1, 2, 30'h30));
        vecs.push_back(mk(0, 0, 1, 30'd5,   0, 1, 0, 30'h0));
        vecs.push_back(mk(0, 0, 1, 30'd6,   0, 1, 1, 30'd5));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 2, 30'd5));
        vecs.push_back(mk(0, 0, 0, 30'h0,   1, 1, 1, 30'd6));
        vecs.push_back(mk(0, 0, 0, 30'h0,   0, 1, 0, 30'h0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].iv, ins(vecs[i].pc), vecs[i].pc, vecs[i].ordy);
            if (vecs[i].chk) begin
                chk_cnt($sformatf("vec%0d", i), vecs[i].cnt);
                if (vecs[i].cnt > 0) begin
                    chk($sformatf("vec%0d.pc", i), 32'(out_pc_o), 32'(vecs[i].hpc));
                    chk($sformatf("vec%0d.instr", i), out_instr_o, ins(vecs[i].hpc));
                end
            end
            tick();
        end

        // Streaming: push and pop every cycle, occupancy settles at one.
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, ins(30'(i)), 30'(i), 1);
            chk_cnt($sformatf("stream%0d", i), (i == 0) ? 0 : 1);
            if (i > 0) chk($sformatf("stream%0d.pc", i), 32'(out_pc_o), 32'(i - 1));
            tick();
        end
        step(0, 0, 0, 32'h0, 30'h0, 1);
        chk_cnt("stream_tail", 1);
        chk("stream_tail.pc", 32'(out_pc_o), 32'd19);
        tick();
        step(0, 0, 0, 32'h0, 30'h0, 0);
        chk_cnt("stream_done", 0);
        tick();

        // Flush held for three cycles with offers present, then a normal push.
        step(0, 0, 1, ins(30'h40), 30'h40, 0); tick();
        step(0, 0, 1, ins(30'h41), 30'h41, 0); tick();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, ins(30'h50), 30'h50, 1);
            chk_cnt($sformatf("hold_flush%0d", i), (i == 0) ? 2 : 0);
            tick();
        end
        step(0, 0, 1, ins(30'h60), 30'h60, 0);
        chk_cnt("post_flush", 0);
        tick();
        step(0, 0, 0, 32'h0, 30'h0, 1);
        chk_cnt("post_flush_push", 1);
        chk("post_flush_push.pc", 32'(out_pc_o), 32'h60);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 24) == 0),
                 1'($urandom), $urandom, 30'($urandom), 1'($urandom));
            tick();
        end
        step(0, 0, 0, 32'h0, 30'h0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_queue.md
Name: riscv_fetch_queue

Overview:
Small instruction queue between the instruction fetch unit and the decode stage. It decouples fetch latency from decode stalls and holds up to DEPTH instruction/PC pairs in order. A branch/jump redirect flushes all queued entries in one cycle. Both sides use a valid/ready handshake, and no input-to-output combinational path exists.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
CW, $clog2(DEPTH)+1, derived width of count_o; not to be overridden

Ports:
clk_i  in  1  clock, all state updates on rising edge
reset_i  in  1  synchronous, active-high reset
flush_i  in  1  redirect; discard all entries and any same-cycle push
in_valid_i  in  1  fetch side: entry offered
in_ready_o  out  1  fetch side: queue can accept
in_instr_i  in  32  fetched instruction word
in_pc_i  in  30  word address of in_instr_i
out_valid_o  out  1  decode side: head entry valid
out_ready_i  in  1  decode side: head consumed this cycle
out_instr_o  out  32  head instruction
out_pc_o  out  30  head word address
count_o  out  CW  number of valid entries, 0..DEPTH
empty_o  out  1  count_o == 0
full_o  out  1  count_o == DEPTH

Behaviour:
- Storage: DEPTH-entry circular buffer of {instr, pc}. Read and write pointers are CW bits wide; the MSB is the wrap bit. Pointers wrap DEPTH-1 -> 0 by natural overflow.
- Reset (reset_i high at the edge):
  - pointers and count go to 0.
  - out_valid_o=0, in_ready_o=1, count_o=0, empty_o=1, full_o=0.
  - Storage contents are not reset.
  - reset_i has priority over flush_i and over all handshakes.
- Derived outputs depend only on registered pointers/count:
  - in_ready_o = !full_o.
  - out_valid_o = !empty_o.
  - in_ready_o must not depend on out_ready_i.
- push = in_valid_i && in_ready_o && !flush_i. On push, the entry is written at the write pointer and the write pointer increments.
- pop = out_valid_o && out_ready_i && !flush_i. On pop, the read pointer increments.
- count_o next = count_o + push - pop. A simultaneous push and pop leaves count unchanged.
- Latency: an entry pushed at edge N is presented at out_* after edge N (visible in cycle N+1). There is no empty bypass.
- First-word fall-through: out_instr_o/out_pc_o combinationally show the entry at the read pointer.
- Stability: while out_valid_o && !out_ready_i, out_instr_o/out_pc_o hold stable.
- When out_valid_o=0, out_instr_o/out_pc_o are don't-care and are not checked.
- Full: in_ready_o=0, so no push occurs even if a pop happens the same cycle. in_ready_o returns to 1 the cycle after a pop.
- Empty: out_valid_o=0; out_ready_i is ignored.
- Flush (flush_i high at the edge, reset_i low):
  - both pointers go to 0 and count goes to 0.
  - out_valid_o=0 and in_ready_o=1 from the next cycle.
  - a push or pop handshake in the flush cycle has no effect.
- Flush held for multiple cycles keeps the queue empty throughout. An entry offered in the first cycle after flush deasserts is accepted normally.
- Order is strictly FIFO; entries are never duplicated or dropped except by flush/reset.

Test Plan:
- Reset then idle, DEPTH=4 -> count_o=0, empty_o=1, full_o=0, in_ready_o=1, out_valid_o=0.
- Push instr 0x00000013/pc 0, 0x00100093/pc 1, 0x00200113/pc 2 with out_ready_i=0 -> count_o=3; out_* shows 0x00000013/pc 0 and holds stable. Then out_ready_i=1 for 3 cycles -> pops in order pc 0,1,2, ending empty_o=1.
- Push 4 entries (pc 10..13) with out_ready_i=0 -> full_o=1, in_ready_o=0. A 5th offer (pc 14) held valid is not accepted. One pop -> in_ready_o=1 next cycle, pc 14 accepted; drain order is 11,12,13,14.
- Continuous in_valid_i=1 and out_ready_i=1 over 20 cycles, pc 0..19 -> count_o stays at 1 after the first cycle; output pcs 0..19 in order with no gaps after the first; pointers wrap correctly.
- 3 entries queued, then flush_i=1 in the same cycle as in_valid_i=1 (pc 0x100) and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0. pc 0x100 is never output, and the next push pc 0x200 appears as the head one cycle later.
- reset_i=1 asserted with 2 entries queued and flush_i=1 simultaneously -> reset values next cycle. After release, the first pushed entry (pc 5) is the first popped.
